// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- constants shared by the writeback stage and its clear sequencer.
//   * instruction field positions (opcode, destination register)
//   * opcode range boundaries that select the write-data source
//   * status flag bit indices
//   * FSM state type
// -----------------------------------------------------------------------------
package wb_pkg;

    // Instruction field positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int DST_MSB = 26;
    localparam int DST_LSB = 23;

    // Opcode classes: 0 = NOP, 1..12 write in_data, 13..17 write in_abs,
    // 18..31 update flags only.
    localparam logic [4:0] OP_NOP     = 5'd0;
    localparam logic [4:0] ABS_FIRST  = 5'd13;
    localparam logic [4:0] ABS_LAST   = 5'd17;
    localparam logic [4:0] WRITE_LAST = 5'd17;

    // Status flag bit indices
    localparam int FLAG_FULL  = 0;
    localparam int FLAG_ABOVE = 1;
    localparam int FLAG_EQUAL = 2;
    localparam int FLAG_BELOW = 3;
    localparam int FLAG_ERR   = 4;
    localparam int NFLAGS     = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_clear_seq.sv
// -----------------------------------------------------------------------------
// wb_clear_seq -- counter and address generator for the scratch-register
// clear sequence.
//   clk, rst  : clock, asynchronous active-high reset
//   adv_i     : advance the counter by one step this cycle
//   addr_o    : current clear address, (CLR_BASE + k) mod NREGS
//   last_o    : current step is the final one (k == CLR_COUNT-1)
// The counter wraps back to zero after the last step, so it is already
// primed for the next sequence without an explicit start pulse.
// -----------------------------------------------------------------------------
module wb_clear_seq
    import wb_pkg::*;
#(
    parameter int NREGS     = 16,
    parameter int CLR_BASE  = 12,
    parameter int CLR_COUNT = 4,
    parameter int AW        = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam int CW = (CLR_COUNT > 1) ? $clog2(CLR_COUNT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == CW'(CLR_COUNT - 1));

    // Wrap-around of the scratch window past the top of the register file.
    assign addr_o = AW'((CLR_BASE + int'(cnt_q)) % NREGS);

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback -- final pipeline stage: turns execute-stage entries into
// register-file writes, architectural flag updates and a sticky error bit,
// and runs a scratch-register clear sequence on request.
//
// Handshake: an entry transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is 1 only in IDLE; during CLEAR in_valid is
// ignored and upstream must hold its entry until in_ready returns.
//
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid / in_ready      : entry handshake
//   in_data, in_abs          : result / absolute-value result
//   in_instr                 : opcode [31:27], destination [26:23]
//   in_flags                 : status flags, [4] = error
//   in_reset_regs            : entry requests a scratch clear sequence
//   err_clear                : clear the sticky error flag
//   rf_we/rf_waddr/rf_wdata  : registered register-file write port
//   flags_q, err_sticky      : architectural flags, sticky error
//   busy                     : clear sequence in progress
//   dbg_state                : current FSM state
// -----------------------------------------------------------------------------
module writeback
    import wb_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int NREGS     = 16,
    parameter int CLR_BASE  = 12,
    parameter int CLR_COUNT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DWIDTH-1:0]         in_data,
    input  logic [DWIDTH-1:0]         in_instr,
    input  logic [DWIDTH-1:0]         in_abs,
    input  logic [NFLAGS-1:0]         in_flags,
    input  logic                      in_reset_regs,
    input  logic                      err_clear,
    output logic                      rf_we,
    output logic [$clog2(NREGS)-1:0]  rf_waddr,
    output logic [DWIDTH-1:0]         rf_wdata,
    output logic [NFLAGS-1:0]         flags_q,
    output logic                      err_sticky,
    output logic                      busy,
    output wb_state_e                 dbg_state
);

    localparam int AW = $clog2(NREGS);

    wb_state_e         state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [DWIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NFLAGS-1:0] flags_d;
    logic              err_q, err_d;
    logic [AW-1:0]     skip_q, skip_d;

    logic              accept;
    logic [4:0]        opcode;
    logic [AW-1:0]     dest;
    logic              seq_adv;
    logic [AW-1:0]     seq_addr;
    logic              seq_last;
    logic              unused_instr;

    assign opcode       = in_instr[OP_MSB:OP_LSB];
    assign dest         = AW'(in_instr[DST_MSB:DST_LSB]);
    assign unused_instr = ^in_instr;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state_q;

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign err_sticky = err_q;

    wb_clear_seq #(
        .NREGS     (NREGS),
        .CLR_BASE  (CLR_BASE),
        .CLR_COUNT (CLR_COUNT),
        .AW        (AW)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (seq_adv),
        .addr_o (seq_addr),
        .last_o (seq_last)
    );

    // Next-state and write-port logic. Address and data hold their last
    // values whenever no write is issued.
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        flags_d    = flags_q;
        skip_d     = skip_q;
        seq_adv    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (opcode != OP_NOP) begin
                        flags_d = in_flags;
                    end
                    if (opcode != OP_NOP && opcode <= WRITE_LAST) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = dest;
                        rf_wdata_d = (opcode >= ABS_FIRST && opcode <= ABS_LAST)
                                     ? in_abs : in_data;
                    end
                    if (in_reset_regs) begin
                        state_d = ST_CLEAR;
                        skip_d  = dest;
                    end
                end
            end
            ST_CLEAR: begin
                seq_adv = 1'b1;
                // Do not zero the register the triggering entry just wrote;
                // the step still consumes a cycle so duration is fixed.
                if (seq_addr != skip_q) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = seq_addr;
                    rf_wdata_d = '0;
                end
                if (seq_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A newly reported error wins over a simultaneous clear request.
    always_comb begin
        err_d = err_q;
        if (accept && in_flags[FLAG_ERR]) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
            skip_q     <= '0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
            skip_q     <= skip_d;
        end
    end

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;
  import wb_pkg::*;

  localparam int CLR_COUNT = 4;
  localparam int W = 32 + 4 + 32;  // {cycle stamp, addr, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid = 0, in_reset_regs = 0, err_clear = 0;
  logic [31:0] in_data = 0, in_instr = 0, in_abs = 0;
  logic [4:0]  in_flags = 0;
  logic        in_ready, rf_we, err_sticky, busy;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  flags_q;
  wb_state_e   dbg_state;
  // second instance: scratch window wraps past the top of the file
  logic        w_in_ready, w_rf_we, w_err_sticky, w_busy;
  logic [3:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic [4:0]  w_flags_q;
  wb_state_e   w_dbg_state;

  writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_instr(in_instr), .in_abs(in_abs), .in_flags(in_flags),
    .in_reset_regs(in_reset_regs), .err_clear(err_clear),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags_q(flags_q), .err_sticky(err_sticky), .busy(busy), .dbg_state(dbg_state)
  );

  writeback #(.CLR_BASE(14)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .in_instr(in_instr), .in_abs(in_abs), .in_flags(in_flags),
    .in_reset_regs(in_reset_regs), .err_clear(err_clear),
    .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
    .flags_q(w_flags_q), .err_sticky(w_err_sticky), .busy(w_busy), .dbg_state(w_dbg_state)
  );

  // ---------------- reference model state ----------------
  logic [W-1:0] exp_q[$];    // expected writes, base 12
  logic [W-1:0] exp_w_q[$];  // expected writes, base 14
  int          busy_left = 0;
  logic [4:0]  flags_m = 0;
  logic        err_m = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected zero writes of a clear sequence for a given scratch base.
  task automatic push_clear(input int base, input logic [3:0] dst, input logic [31:0] c0);
    for (int k = 0; k < CLR_COUNT; k++) begin
      logic [3:0] a;
      a = 4'((base + k) % 16);
      if (a != dst) begin
        if (base == 12) exp_q.push_back({c0 + 32'(k), a, 32'h0});
        else            exp_w_q.push_back({c0 + 32'(k), a, 32'h0});
      end
    end
  endtask

  // ---------------- driver: one cycle per call ----------------
  task automatic step(input logic v, input logic [4:0] op, input logic [3:0] dst,
                      input logic [31:0] d, input logic [31:0] a, input logic [4:0] fl,
                      input logic rr, input logic ec);
    logic acc;
    in_valid = v; in_instr = {op, dst, 23'($urandom)}; in_data = d; in_abs = a;
    in_flags = fl; in_reset_regs = rr; err_clear = ec;
    acc = v && (busy_left == 0);
    if (acc) begin
      if (op >= 1 && op <= 17) begin
        exp_q.push_back({cyc + 32'd1, dst, (op >= 13) ? a : d});
        exp_w_q.push_back({cyc + 32'd1, dst, (op >= 13) ? a : d});
      end
      if (rr) begin
        push_clear(12, dst, cyc + 32'd2);
        push_clear(14, dst, cyc + 32'd2);
      end
    end
    @(posedge clk); #1;
    if (busy_left > 0) busy_left--;
    if (acc && rr) busy_left = CLR_COUNT;
    if (acc && op != 0) flags_m = fl;
    if (acc && fl[4]) err_m = 1'b1;
    else if (ec) err_m = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, busy_left == 0);
      chk("busy", busy, busy_left != 0);
      chk("dbg_state", dbg_state, (busy_left != 0) ? ST_CLEAR : ST_IDLE);
      chk("flags_q", flags_q, flags_m);
      chk("err_sticky", err_sticky, err_m);
      while (exp_q.size() != 0 && exp_q[0][W-1:36] < cyc) begin
        mon_e = exp_q.pop_front();
        chk("rf_missing_write_cycle", cyc, mon_e[W-1:36]);
      end
      if (rf_we) begin
        if (exp_q.size() == 0) chk("rf_unexpected_write", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rf_write_cycle", cyc, mon_e[W-1:36]);
          chk("rf_waddr", rf_waddr, mon_e[35:32]);
          chk("rf_wdata", rf_wdata, mon_e[31:0]);
        end
      end
      while (exp_w_q.size() != 0 && exp_w_q[0][W-1:36] < cyc) begin
        mon_e = exp_w_q.pop_front();
        chk("wrap_missing_write_cycle", cyc, mon_e[W-1:36]);
      end
      if (w_rf_we) begin
        if (exp_w_q.size() == 0) chk("wrap_unexpected_write", 1, 0);
        else begin
          mon_e = exp_w_q.pop_front();
          chk("wrap_write_cycle", cyc, mon_e[W-1:36]);
          chk("wrap_waddr", w_rf_waddr, mon_e[35:32]);
          chk("wrap_wdata", w_rf_wdata, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_flags_q", flags_q, 0);
    chk("reset_err_sticky", err_sticky, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // plain write: opcode 3, dest 5
    step(1, 5'd3, 4'd5, 32'hDEADBEEF, 32'h1234, 5'b00100, 0, 0);
    chk("op3_we", rf_we, 1);
    chk("op3_waddr", rf_waddr, 5);
    chk("op3_wdata", rf_wdata, 32'hDEADBEEF);
    idle(2);

    // abs write with clear sequence, dest outside the scratch window;
    // in_valid held high during CLEAR must be ignored
    step(1, 5'd14, 4'd2, 32'h55, 32'h7, 5'b00010, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 5'd5, 4'd9, 32'hABCD, 32'h1, 5'b01000, 0, 0);
    idle(3);

    // clear sequence whose destination lies in the scratch window
    step(1, 5'd14, 4'd13, 32'h66, 32'h9, 5'b00001, 1, 0);
    idle(7);

    // error set wins over simultaneous clear, then clear alone
    step(1, 5'd20, 4'd1, 32'h0, 32'h0, 5'b10001, 0, 1);
    chk("err_set_wins", err_sticky, 1);
    chk("err_flags", flags_q, 5'b10001);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("err_clear_alone", err_sticky, 0);
    step(1, 5'd0, 4'd3, 32'h77, 32'h0, 5'b01110, 0, 0);  // NOP keeps flags
    idle(2);

    // reset in the second CLEAR cycle
    step(1, 5'd5, 4'd3, 32'h88, 32'h0, 5'b10100, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("abort_rf_we", rf_we, 0);
    chk("abort_rf_waddr", rf_waddr, 0);
    chk("abort_rf_wdata", rf_wdata, 0);
    chk("abort_flags_q", flags_q, 0);
    chk("abort_err_sticky", err_sticky, 0);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    exp_w_q.delete();
    busy_left = 0; flags_m = 0; err_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    idle(6);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] fl;
      fl = 5'($urandom);
      if ($urandom_range(0, 3) != 0) fl[4] = 1'b0;
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 4'($urandom),
           $urandom, $urandom, fl, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    idle(8);
    chk("queue_drained", exp_q.size(), 0);
    chk("wrap_queue_drained", exp_w_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
